// File: rtl/core_pkg.sv
// Opcodes shared with the decode control unit, plus the hazard sequencer state encoding.
package core_pkg;

  localparam logic [5:0] OP_ADDU = 6'b000001;
  localparam logic [5:0] OP_DIV  = 6'b000110;
  localparam logic [5:0] OP_J    = 6'b000111;
  localparam logic [5:0] OP_BEQ  = 6'b001001;
  localparam logic [5:0] OP_SC   = 6'b001011;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DIV_WAIT,
    ST_DIV_DRAIN
  } seq_state_e;

  // J carries an absolute target, so its rs field is not a register read.
  function automatic logic reads_rs(input logic [5:0] op);
    return op != OP_J;
  endfunction

  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_ADDU) || (op == OP_DIV) || (op == OP_BEQ) || (op == OP_SC);
  endfunction

endpackage

// File: rtl/div_watchdog.sv
// Divider busy-cycle counter; flags expiry when the divider overstays its cycle budget.
module div_watchdog #(
  parameter int unsigned DIV_MAX_CYCLES = 34,
  parameter int unsigned CNT_W          = $clog2(DIV_MAX_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic busy,
  input  logic done,
  output logic expire
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DIV_MAX_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (busy && (count != LIMIT)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire = busy && !done && (count == LIMIT);

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// Pipeline flow control: load-use bubbles, taken-branch flushes and divider freeze.
module pipeline_hazard_sequencer
  import core_pkg::*;
#(
  parameter int unsigned DIV_MAX_CYCLES = 34,
  parameter int unsigned CNT_W          = $clog2(DIV_MAX_CYCLES)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  id_opcode,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [5:0]  ex_opcode,
  input  logic [4:0]  ex_rd,
  input  logic        ex_MEMORY_READ,
  input  logic        branch_taken,
  input  logic        div_done,
  output logic        hazard,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_write,
  output logic        ifid_flush,
  output logic        div_start,
  output logic        div_busy,
  output logic        div_timeout,
  output logic [15:0] stall_cycles
);

  seq_state_e state, state_nxt;
  logic       load_use;
  logic       wd_expire;
  logic       timeout_set;

  assign load_use = ex_MEMORY_READ && (ex_rd != '0) &&
                    (((ex_rd == id_rs) && reads_rs(id_opcode)) ||
                     ((ex_rd == id_rt) && reads_rt(id_opcode)));

  div_watchdog #(
    .DIV_MAX_CYCLES (DIV_MAX_CYCLES),
    .CNT_W          (CNT_W)
  ) u_div_watchdog (
    .clk    (clk),
    .reset  (reset),
    .start  (div_start),
    .busy   (div_busy),
    .done   (div_done),
    .expire (wd_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    hazard      = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    ifid_flush  = 1'b0;
    div_start   = 1'b0;
    div_busy    = 1'b0;
    timeout_set = 1'b0;
    case (state)
      ST_DIV_WAIT: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_write = 1'b0;
        div_busy   = 1'b1;
        if (div_done) begin
          state_nxt = ST_DIV_DRAIN;
        end else if (wd_expire) begin
          timeout_set = 1'b1;
          state_nxt   = ST_DIV_DRAIN;
        end
      end
      default: begin
        // Reset held with a DIV still in EX must not relaunch the aborted divide.
        if ((state == ST_RUN) && !reset && (ex_opcode == OP_DIV)) begin
          div_start  = 1'b1;
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_write = 1'b0;
          state_nxt  = ST_DIV_WAIT;
        end else begin
          if (branch_taken) begin
            ifid_flush = 1'b1;
            hazard     = 1'b1;
          end else if (load_use) begin
            hazard     = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
          end
          state_nxt = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_timeout <= 1'b0;
    end else if (timeout_set) begin
      div_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (!pc_write && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule
